// File: rtl/ook_frame_sched_pkg.sv
// Shared types and helpers for the OOK frame scheduler.
package ook_sched_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARM     = 3'd1,
    HEAD    = 3'd2,
    PAYLOAD = 3'd3,
    GAP     = 3'd4
  } state_t;

  localparam int HEAD_LEN_DEF = 10;

  function automatic int max_w(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ook_frame_sched_if.sv
// Host-side control/config and generator-side outputs of the frame scheduler.
interface ook_frame_sched_if #(
  parameter int NUM_CH = 3,
  parameter int LEN_W  = 16,
  parameter int GAP_W  = 8
);
  logic              start;
  logic              stop;
  logic              mode;
  logic [NUM_CH-1:0] ch_en;
  logic [LEN_W-1:0]  payload_len;
  logic [GAP_W-1:0]  gap_len;
  logic [LEN_W-1:0]  frame_cnt;

  logic [NUM_CH-1:0] gen_rst;
  logic [NUM_CH-1:0] gen_send_enable;
  logic [NUM_CH-1:0] active_ch;
  logic              busy;
  logic              frame_done;
  logic [LEN_W-1:0]  frames_sent;

  modport master (
    output start, stop, mode, ch_en, payload_len, gap_len, frame_cnt,
    input  gen_rst, gen_send_enable, active_ch, busy, frame_done, frames_sent
  );

  modport slave (
    input  start, stop, mode, ch_en, payload_len, gap_len, frame_cnt,
    output gen_rst, gen_send_enable, active_ch, busy, frame_done, frames_sent
  );
endinterface

// File: rtl/ook_frame_sched_rr_next_ch.sv
// Round-robin lane picker: first enabled lane strictly above the current one,
// wrapping to lane 0; returns the current lane again if it is the only one enabled.
module rr_next_ch #(
  parameter int NUM_CH = 3
) (
  input  logic [NUM_CH-1:0] mask,
  input  logic [NUM_CH-1:0] cur,
  output logic [NUM_CH-1:0] nxt
);
  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  int               cur_idx;
  logic [IDX_W-1:0] idx;
  logic             found;

  always_comb begin
    cur_idx = 0;
    idx     = '0;
    found   = 1'b0;
    nxt     = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cur[i]) cur_idx = i;
    end
    for (int k = 1; k <= NUM_CH; k++) begin
      idx = IDX_W'((cur_idx + k) % NUM_CH);
      if (!found && mask[idx]) begin
        nxt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end
endmodule

// File: rtl/ook_frame_sched.sv
// Frame sequencer for the R/G/B OOK generator lanes: header, PRBS payload, gap,
// repeated per run, with the generators held in reset outside their frame.
//
// state   | meaning
// IDLE    | all generators in reset, waiting for start
// ARM     | release selected lanes, pulse send_enable (1 cycle)
// HEAD    | generators emit the comma header (HEAD_LEN cycles)
// PAYLOAD | generators stream PRBS (max(payload_len,1) cycles)
// GAP     | selected lanes back in reset (max(gap_len,1) cycles)
module ook_frame_sched
  import ook_sched_pkg::*;
#(
  parameter int NUM_CH   = 3,
  parameter int LEN_W    = 16,
  parameter int GAP_W    = 8,
  parameter int HEAD_LEN = HEAD_LEN_DEF
) (
  input logic               clk,
  input logic               rst_n,
  ook_frame_sched_if.slave  bus
);
  localparam int CNT_W = max_w(max_w(LEN_W, GAP_W), $clog2(HEAD_LEN));
  localparam logic [CNT_W-1:0]  HEAD_LAST = CNT_W'(HEAD_LEN - 1);
  localparam logic [NUM_CH-1:0] TOP_LANE  = NUM_CH'(1) << (NUM_CH - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              cnt_ld;

  logic              mode_q;
  logic [NUM_CH-1:0] ch_en_q;
  logic [LEN_W-1:0]  pay_q;
  logic [GAP_W-1:0]  gap_q;
  logic [LEN_W-1:0]  fcnt_q;
  logic [LEN_W-1:0]  frames_q;
  logic              stop_pend_q;

  logic [NUM_CH-1:0] sel_q, sel_d;
  logic              sel_ld;
  logic              latch;
  logic              frame_end;
  logic              run_done;

  logic [NUM_CH-1:0] rr_mask, rr_cur, rr_nxt;
  logic [CNT_W-1:0]  pay_last, gap_last;

  logic [NUM_CH-1:0] gen_rst_c, gse_c, act_c;

  // Zero lengths behave as one cycle, hence the clamp before the minus-one load.
  assign pay_last = (pay_q == '0) ? '0 : CNT_W'(pay_q - LEN_W'(1));
  assign gap_last = (gap_q == '0) ? '0 : CNT_W'(gap_q - GAP_W'(1));
  assign run_done = (fcnt_q != '0) && (frames_q == fcnt_q);

  // From IDLE the picker starts above the top lane so it lands on the lowest enabled one.
  assign rr_mask = (state_q == IDLE) ? bus.ch_en : ch_en_q;
  assign rr_cur  = (state_q == IDLE) ? TOP_LANE  : sel_q;

  rr_next_ch #(.NUM_CH(NUM_CH)) u_rr (
    .mask (rr_mask),
    .cur  (rr_cur),
    .nxt  (rr_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    cnt_ld    = 1'b0;
    cnt_d     = '0;
    latch     = 1'b0;
    sel_ld    = 1'b0;
    sel_d     = sel_q;
    frame_end = 1'b0;
    gen_rst_c = '1;
    gse_c     = '0;
    act_c     = '0;
    case (state_q)
      IDLE: begin
        if (bus.start && (bus.ch_en != '0)) begin
          state_d = ARM;
          latch   = 1'b1;
          sel_ld  = 1'b1;
          sel_d   = bus.mode ? rr_nxt : bus.ch_en;
        end
      end
      ARM: begin
        gen_rst_c = ~sel_q;
        gse_c     = sel_q;
        act_c     = sel_q;
        state_d   = HEAD;
        cnt_ld    = 1'b1;
        cnt_d     = HEAD_LAST;
      end
      HEAD: begin
        gen_rst_c = ~sel_q;
        act_c     = sel_q;
        if (cnt_q == '0) begin
          state_d = PAYLOAD;
          cnt_ld  = 1'b1;
          cnt_d   = pay_last;
        end
      end
      PAYLOAD: begin
        gen_rst_c = ~sel_q;
        act_c     = sel_q;
        if (cnt_q == '0) begin
          frame_end = 1'b1;
          state_d   = GAP;
          cnt_ld    = 1'b1;
          cnt_d     = gap_last;
        end
      end
      GAP: begin
        if (cnt_q == '0) begin
          if (stop_pend_q || bus.stop || run_done) begin
            state_d = IDLE;
          end else begin
            state_d = ARM;
            sel_ld  = 1'b1;
            sel_d   = mode_q ? rr_nxt : ch_en_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      mode_q      <= 1'b0;
      ch_en_q     <= '0;
      pay_q       <= '0;
      gap_q       <= '0;
      fcnt_q      <= '0;
      frames_q    <= '0;
      stop_pend_q <= 1'b0;
      sel_q       <= NUM_CH'(1);
    end else begin
      if (cnt_ld)              cnt_q <= cnt_d;
      else if (cnt_q != '0)    cnt_q <= cnt_q - CNT_W'(1);

      if (latch) begin
        mode_q   <= bus.mode;
        ch_en_q  <= bus.ch_en;
        pay_q    <= bus.payload_len;
        gap_q    <= bus.gap_len;
        fcnt_q   <= bus.frame_cnt;
        frames_q <= '0;
      end else if (frame_end) begin
        frames_q <= frames_q + LEN_W'(1);
      end

      if (sel_ld) sel_q <= sel_d;

      if (state_q == IDLE) stop_pend_q <= 1'b0;
      else if (bus.stop)   stop_pend_q <= 1'b1;
    end
  end

  assign bus.gen_rst         = gen_rst_c;
  assign bus.gen_send_enable = gse_c;
  assign bus.active_ch       = act_c;
  assign bus.busy            = (state_q != IDLE);
  assign bus.frame_done      = frame_end;
  assign bus.frames_sent     = frames_q;

endmodule

// File: tb/tb_ook_frame_sched.sv
// Self-checking bench for ook_frame_sched: per-cycle expectations derived from a
// frame timeline model (ARM + header + payload + gap per frame).
module tb_ook_frame_sched;
  localparam int NUM_CH   = 3;
  localparam int LEN_W    = 16;
  localparam int GAP_W    = 8;
  localparam int HEAD_LEN = 10;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ook_frame_sched_if #(.NUM_CH(NUM_CH), .LEN_W(LEN_W), .GAP_W(GAP_W)) bus ();

  ook_frame_sched #(.NUM_CH(NUM_CH), .LEN_W(LEN_W), .GAP_W(GAP_W), .HEAD_LEN(HEAD_LEN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp;
  int n_bad;

  int         gse_cyc[$];
  int         done_cyc[$];
  logic [2:0] act_seq[$];
  int         busy_fall;
  bit         lane1_held;

  task automatic run_frames(input string nm, input logic m, input logic [2:0] en,
                            input int pay, input int gap, input int fcnt,
                            input int stop_frame, input int stop_off,
                            input bit stop_with_start, input bit scramble, input bit restart_head);
    int pe, ge, per, nfr, t_stop, f, off, efs;
    int lanes[$];
    logic [2:0] sel, e_gse, e_act, e_rst;
    logic e_busy, e_done, prev_busy;
    pe  = (pay == 0) ? 1 : pay;
    ge  = (gap == 0) ? 1 : gap;
    per = 1 + HEAD_LEN + pe + ge;
    nfr = (fcnt != 0) ? fcnt : stop_frame + 1;
    for (int i = 0; i < NUM_CH; i++) if (en[i]) lanes.push_back(i);
    t_stop = (stop_frame >= 0) ? stop_frame * per + 2 + HEAD_LEN + stop_off : -1;
    gse_cyc.delete(); done_cyc.delete(); act_seq.delete();
    busy_fall = -1; lane1_held = 1'b1; prev_busy = 1'b1;

    @(posedge clk); #1;
    bus.mode = m; bus.ch_en = en;
    bus.payload_len = LEN_W'(pay); bus.gap_len = GAP_W'(gap); bus.frame_cnt = LEN_W'(fcnt);
    bus.start = 1'b1; bus.stop = stop_with_start;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.stop = 1'b0;

    for (int t = 1; t <= nfr * per + 4; t++) begin
      f   = (t - 1) / per;
      off = (t - 1) % per;
      e_busy = (t <= nfr * per);
      sel = '0;
      if (e_busy) sel = m ? 3'(1 << lanes[f % lanes.size()]) : en;
      e_gse  = (e_busy && off == 0) ? sel : 3'b000;
      e_act  = (e_busy && off <= HEAD_LEN + pe) ? sel : 3'b000;
      e_rst  = ~e_act;
      e_done = e_busy && (off == HEAD_LEN + pe);
      efs = 0;
      for (int fp = 0; fp < nfr; fp++) if (fp * per + 1 + HEAD_LEN + pe < t) efs++;

      n_cmp++;
      if (bus.busy !== e_busy) begin
        n_bad++; if (n_bad <= 40) $display("FAIL %s busy t=%0d got %b want %b", nm, t, bus.busy, e_busy);
      end
      n_cmp++;
      if (bus.gen_send_enable !== e_gse) begin
        n_bad++; if (n_bad <= 40) $display("FAIL %s gen_send_enable t=%0d got %b want %b", nm, t, bus.gen_send_enable, e_gse);
      end
      n_cmp++;
      if (bus.active_ch !== e_act) begin
        n_bad++; if (n_bad <= 40) $display("FAIL %s active_ch t=%0d got %b want %b", nm, t, bus.active_ch, e_act);
      end
      n_cmp++;
      if (bus.gen_rst !== e_rst) begin
        n_bad++; if (n_bad <= 40) $display("FAIL %s gen_rst t=%0d got %b want %b", nm, t, bus.gen_rst, e_rst);
      end
      n_cmp++;
      if (bus.frame_done !== e_done) begin
        n_bad++; if (n_bad <= 40) $display("FAIL %s frame_done t=%0d got %b want %b", nm, t, bus.frame_done, e_done);
      end
      n_cmp++;
      if (bus.frames_sent !== LEN_W'(efs)) begin
        n_bad++; if (n_bad <= 40) $display("FAIL %s frames_sent t=%0d got %0d want %0d", nm, t, bus.frames_sent, efs);
      end

      if (bus.gen_send_enable != 3'b000) begin
        gse_cyc.push_back(t);
        act_seq.push_back(bus.active_ch);
      end
      if (bus.frame_done) done_cyc.push_back(t);
      if (prev_busy && !bus.busy && busy_fall < 0) busy_fall = t;
      prev_busy = bus.busy;
      if (bus.gen_rst[1] !== 1'b1) lane1_held = 1'b0;

      bus.stop  = (t == t_stop);
      bus.start = restart_head && (t == 5);
      if (scramble || (restart_head && t == 5)) begin
        bus.mode        = 1'($urandom_range(0, 1));
        bus.ch_en       = 3'($urandom_range(1, 7));
        bus.payload_len = LEN_W'($urandom_range(0, 40));
        bus.gap_len     = GAP_W'($urandom_range(0, 9));
        bus.frame_cnt   = LEN_W'($urandom_range(0, 5));
      end
      @(posedge clk); #1;
    end
    bus.start = 1'b0; bus.stop = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.stop = 1'b0; bus.mode = 1'b0; bus.ch_en = '0;
    bus.payload_len = '0; bus.gap_len = '0; bus.frame_cnt = '0;
    #13;
    n_cmp++; if (bus.gen_rst !== 3'b111) begin n_bad++; $display("FAIL reset gen_rst got %b want 111", bus.gen_rst); end
    n_cmp++; if (bus.gen_send_enable !== 3'b000) begin n_bad++; $display("FAIL reset gen_send_enable got %b want 000", bus.gen_send_enable); end
    n_cmp++; if (bus.active_ch !== 3'b000) begin n_bad++; $display("FAIL reset active_ch got %b want 000", bus.active_ch); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset busy got %b want 0", bus.busy); end
    n_cmp++; if (bus.frame_done !== 1'b0) begin n_bad++; $display("FAIL reset frame_done got %b want 0", bus.frame_done); end
    n_cmp++; if (bus.frames_sent !== '0) begin n_bad++; $display("FAIL reset frames_sent got %0d want 0", bus.frames_sent); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_parallel;
    run_frames("parallel", 1'b0, 3'b111, 20, 4, 2, -1, 0, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (gse_cyc.size() != 2 || gse_cyc[0] != 1 || gse_cyc[1] != 36) begin
      n_bad++; $display("FAIL parallel send_enable cycles got %p want 1,36", gse_cyc); end
    n_cmp++; if (done_cyc.size() != 2 || done_cyc[0] != 31 || done_cyc[1] != 66) begin
      n_bad++; $display("FAIL parallel frame_done cycles got %p want 31,66", done_cyc); end
    n_cmp++; if (busy_fall != 71) begin n_bad++; $display("FAIL parallel busy fall got %0d want 71", busy_fall); end
    n_cmp++; if (bus.frames_sent !== 16'd2) begin n_bad++; $display("FAIL parallel frames_sent got %0d want 2", bus.frames_sent); end
  endtask

  task automatic test_round_robin;
    run_frames("round_robin", 1'b1, 3'b101, $urandom_range(1, 8), $urandom_range(1, 5), 3, -1, 0, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (act_seq.size() != 3 || act_seq[0] !== 3'b001 || act_seq[1] !== 3'b100 || act_seq[2] !== 3'b001) begin
      n_bad++; $display("FAIL round_robin active sequence got %p want 001,100,001", act_seq); end
    n_cmp++; if (lane1_held !== 1'b1) begin n_bad++; $display("FAIL round_robin lane1 gen_rst got released want held"); end
  endtask

  task automatic test_continuous_stop;
    int pay;
    pay = $urandom_range(3, 12);
    run_frames("continuous_stop", 1'($urandom_range(0, 1)), 3'($urandom_range(1, 7)), pay,
               $urandom_range(1, 6), 0, 4, $urandom_range(0, pay - 1), 1'b0, 1'b0, 1'b0);
    n_cmp++; if (bus.frames_sent !== 16'd5) begin n_bad++; $display("FAIL continuous_stop frames_sent got %0d want 5", bus.frames_sent); end
    n_cmp++; if (gse_cyc.size() != 5) begin n_bad++; $display("FAIL continuous_stop send_enable count got %0d want 5", gse_cyc.size()); end
  endtask

  task automatic test_min_lengths;
    run_frames("min_lengths", 1'b0, 3'b011, 0, 0, 3, -1, 0, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (gse_cyc.size() != 3 || gse_cyc[1] - gse_cyc[0] != 13 || gse_cyc[2] - gse_cyc[1] != 13) begin
      n_bad++; $display("FAIL min_lengths frame period got %p want spacing 13", gse_cyc); end
  endtask

  task automatic test_start_no_lanes;
    @(posedge clk); #1;
    bus.ch_en = 3'b000; bus.frame_cnt = 16'd1; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (bus.busy !== 1'b0 || bus.gen_rst !== 3'b111) begin
        n_bad++; $display("FAIL no_lanes busy/gen_rst got %b/%b want 0/111", bus.busy, bus.gen_rst); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_start_during_head;
    run_frames("start_in_head", 1'b1, 3'b110, 6, 3, 2, -1, 0, 1'b0, 1'b1, 1'b1);
    n_cmp++; if (act_seq.size() != 2 || act_seq[0] !== 3'b010 || act_seq[1] !== 3'b100) begin
      n_bad++; $display("FAIL start_in_head active sequence got %p want 010,100", act_seq); end
  endtask

  task automatic test_stop_idle_and_same_cycle;
    @(posedge clk); #1; bus.stop = 1'b1;
    @(posedge clk); #1; bus.stop = 1'b0;
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL stop_idle busy got %b want 0", bus.busy); end
    run_frames("start_stop_same", 1'b0, 3'b100, 5, 2, 2, -1, 0, 1'b1, 1'b0, 1'b0);
    n_cmp++; if (bus.frames_sent !== 16'd2) begin n_bad++; $display("FAIL start_stop_same frames_sent got %0d want 2", bus.frames_sent); end
  endtask

  task automatic test_reset_mid_run;
    @(posedge clk); #1;
    bus.mode = 1'b0; bus.ch_en = 3'b111; bus.payload_len = 16'd10; bus.gap_len = 8'd2;
    bus.frame_cnt = 16'd0; bus.start = 1'b1;
    @(posedge clk); #1; bus.start = 1'b0;
    repeat (14) @(posedge clk);
    #3; rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.gen_rst !== 3'b111) begin n_bad++; $display("FAIL reset_mid gen_rst got %b want 111", bus.gen_rst); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset_mid busy got %b want 0", bus.busy); end
    n_cmp++; if (bus.active_ch !== 3'b000) begin n_bad++; $display("FAIL reset_mid active_ch got %b want 000", bus.active_ch); end
    @(negedge clk); rst_n = 1'b1;
    run_frames("after_reset", 1'b1, 3'b111, 4, 2, 2, -1, 0, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (act_seq.size() != 2 || act_seq[0] !== 3'b001 || act_seq[1] !== 3'b010) begin
      n_bad++; $display("FAIL after_reset active sequence got %p want 001,010", act_seq); end
  endtask

  task automatic test_random;
    for (int r = 0; r < 5; r++) begin
      run_frames("random", 1'($urandom_range(0, 1)), 3'($urandom_range(1, 7)),
                 $urandom_range(0, 15), $urandom_range(0, 6), $urandom_range(1, 3),
                 -1, 0, 1'b0, 1'b1, 1'b0);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset;
    test_parallel;
    test_round_robin;
    test_continuous_stop;
    test_min_lengths;
    test_start_no_lanes;
    test_start_during_head;
    test_stop_idle_and_same_cycle;
    test_reset_mid_run;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ook_frame_sched.md
Name: ook_frame_sched

Overview:
- Sequences up to NUM_CH OOK frame generators (one per R/G/B LED lane) through repeated frames.
- Each frame is a 10-bit comma header, then a PRBS payload of programmable length, then an inter-frame gap.
- Each generator, once started, streams PRBS until reset. This block ends every frame by asserting that lane's generator reset.
- Sits between the host/config registers and the generator instances. Lanes are driven either together (parallel) or one at a time (round-robin time division).

Parameters:
- NUM_CH, 3, number of generator lanes
- LEN_W, 16, width of payload_len, frame_cnt and frames_sent
- GAP_W, 8, width of gap_len
- HEAD_LEN, 10, header length in cycles; must equal the generator's header length

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle pulse; starts a run; config is latched on this cycle
- stop  in  1  single-cycle pulse; graceful stop request
- mode  in  1  0 = parallel (all enabled lanes together), 1 = round-robin
- ch_en  in  NUM_CH  lane enable mask
- payload_len  in  LEN_W  PRBS cycles per frame; 0 is treated as 1
- gap_len  in  GAP_W  gap cycles between frames; 0 is treated as 1
- frame_cnt  in  LEN_W  frames per run; 0 = continuous until stop
- gen_rst  out  NUM_CH  per-lane synchronous active-high generator reset
- gen_send_enable  out  NUM_CH  per-lane send_enable pulse to the generator
- active_ch  out  NUM_CH  one-hot set of lanes currently in a frame
- busy  out  1  high from the cycle after start until return to IDLE
- frame_done  out  1  1-cycle pulse on the last payload cycle of each frame
- frames_sent  out  LEN_W  frames completed this run; wraps at 2^LEN_W

Behaviour:
- Reset values (async, rst_n=0): gen_rst all 1, gen_send_enable 0, active_ch 0, busy 0, frame_done 0, frames_sent 0, state IDLE, RR pointer at lane 0.
- States: IDLE, ARM, HEAD, PAYLOAD, GAP.
- IDLE: gen_rst all 1.
  - start with ch_en!=0: latch mode/ch_en/payload_len/gap_len/frame_cnt, clear frames_sent, go to ARM.
  - start with ch_en==0: ignored, no busy.
  - start while busy: ignored.
- ARM (1 cycle):
  - Selected lanes: gen_rst=0, gen_send_enable=1. Parallel selects all latched enabled lanes; round-robin selects one lane.
  - active_ch is set to the selected lanes. Go to HEAD.
- HEAD: exactly HEAD_LEN cycles. The generators emit the header on these cycles. gen_send_enable=0.
- PAYLOAD: exactly max(payload_len,1) cycles. frame_done pulses on the final cycle, and frames_sent increments on that cycle.
- GAP: exactly max(gap_len,1) cycles. gen_rst=1 on the selected lanes, active_ch=0. On the last GAP cycle:
  - If a stop is pending, or frame_cnt!=0 and frames_sent==frame_cnt: go to IDLE and drop busy next cycle.
  - Otherwise go to ARM. Round-robin advances to the next latched-enabled lane above the current one, wrapping NUM_CH-1 to 0. With a single enabled lane it reselects the same lane.
- Frame period: 1 + HEAD_LEN + payload + gap cycles. For lanes not selected, gen_rst stays 1 throughout.
- stop: sets a sticky stop_pend flag in any busy state. The current frame always completes HEAD/PAYLOAD/GAP. stop_pend clears in IDLE.
- stop in IDLE: no effect.
- start and stop in the same cycle in IDLE: start wins, stop is ignored.
- Reset mid-run: immediate return to reset values.
- Config inputs are ignored while busy; only latched values are used.
- Counters: HEAD/PAYLOAD/GAP share one down-counter of width max(LEN_W, GAP_W, clog2(HEAD_LEN)). It is loaded on state entry with the length minus 1.

Decomposition:
- Package ook_sched_pkg holds:
  - state enum (IDLE=0, ARM=1, HEAD=2, PAYLOAD=3, GAP=4, 3-bit encoding)
  - HEAD_LEN default constant
  - a max-width helper function
- One sub-module, rr_next_ch: combinational round-robin next-lane picker. Inputs: mask, current one-hot. Output: next one-hot.

Test Plan:
- Parallel run, ch_en=3'b111, payload_len=20, gap_len=4, frame_cnt=2, start:
  - gen_send_enable=111 at cycles 1 and 36.
  - frame_done at cycles 31 and 66.
  - busy falls at cycle 71, frames_sent=2.
- Round-robin, ch_en=3'b101, frame_cnt=3: active_ch sequence 001, 100, 001; lane 1 gen_rst held 1 throughout.
- Continuous, frame_cnt=0, stop pulsed mid-PAYLOAD of frame 5:
  - Frame 5 completes with full payload and gap.
  - Then IDLE with frames_sent=5, no further gen_send_enable.
- payload_len=0, gap_len=0: payload and gap each last 1 cycle, frame period = 13 cycles.
- Boundary starts:
  - start with ch_en=0: busy stays 0.
  - start pulsed during HEAD: no restart, latched config unchanged.
- rst_n asserted during PAYLOAD: gen_rst=all 1 and busy=0 immediately. A later start runs normally from lane 0.
